// File: rtl/digital_vfo_if.sv
// ---------------------------------------------------------------------------
// digital_vfo_if : control/status bundle between the PLL loop logic and the VFO
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface digital_vfo_if #(
  parameter int ACC_W = 16
);
  logic [1:0]       adjust_freq;
  logic             sample_cmd;
  logic             load_en;
  logic [ACC_W-1:0] load_inc;
  logic             clock_out;
  logic             clock_rise;
  logic [ACC_W-1:0] cur_inc;
  logic             at_max;
  logic             at_min;
  logic             locked;

  modport master (
    output adjust_freq, sample_cmd, load_en, load_inc,
    input  clock_out, clock_rise, cur_inc, at_max, at_min, locked
  );

  modport slave (
    input  adjust_freq, sample_cmd, load_en, load_inc,
    output clock_out, clock_rise, cur_inc, at_max, at_min, locked
  );
endinterface

`default_nettype wire

// File: rtl/digital_vfo.sv
// ---------------------------------------------------------------------------
// digital_vfo : phase-accumulator NCO with saturating step control and lock flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module digital_vfo #(
  parameter int ACC_W      = 16,
  parameter int BASE_INC   = 'h2000,
  parameter int DELTA_INC  = 16,
  parameter int MAX_DELTA  = 64,
  parameter int LOCK_COUNT = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  digital_vfo_if.slave bus
);

  localparam int EXT_W  = ACC_W + 2;
  localparam int HOLD_W = $clog2(LOCK_COUNT + 1);

  typedef logic signed [EXT_W-1:0] ext_t;

  localparam ext_t             C_CEIL_EXT  = ext_t'(BASE_INC + MAX_DELTA);
  localparam ext_t             C_FLOOR_EXT = ext_t'(BASE_INC - MAX_DELTA);
  localparam ext_t             C_STEP      = ext_t'(DELTA_INC);
  localparam ext_t             C_STEP2     = ext_t'(2 * DELTA_INC);
  localparam logic [ACC_W-1:0] C_CEIL      = ACC_W'(BASE_INC + MAX_DELTA);
  localparam logic [ACC_W-1:0] C_FLOOR     = ACC_W'(BASE_INC - MAX_DELTA);
  localparam logic [ACC_W-1:0] C_BASE      = ACC_W'(BASE_INC);
  localparam logic [HOLD_W-1:0] C_LOCK     = HOLD_W'(LOCK_COUNT);
  localparam logic [HOLD_W-1:0] C_ONE      = HOLD_W'(1);

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_inc;
  logic [HOLD_W-1:0] r_hold;
  logic              r_rise;
  logic              r_locked;
  logic              r_at_max;
  logic              r_at_min;

  logic [ACC_W:0]    w_sum;
  ext_t              w_inc_ext;
  ext_t              w_req;
  logic [ACC_W-1:0]  w_inc_next;
  logic [HOLD_W-1:0] w_hold_next;

  // The carry out of the add is the wrap event that drives clock_rise.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  always_comb begin
    w_inc_ext   = ext_t'({2'b00, r_inc});
    w_req       = w_inc_ext;
    w_hold_next = r_hold;
    if (bus.load_en) begin
      w_req       = ext_t'({2'b00, bus.load_inc});
      w_hold_next = '0;
    end else if (bus.sample_cmd) begin
      case (bus.adjust_freq)
        2'b00:   w_req = w_inc_ext - C_STEP;
        2'b10:   w_req = w_inc_ext + C_STEP;
        2'b11:   w_req = w_inc_ext + C_STEP2;
        default: w_req = w_inc_ext;
      endcase
      if (bus.adjust_freq == 2'b01) begin
        w_hold_next = (r_hold == C_LOCK) ? r_hold : r_hold + C_ONE;
      end else begin
        w_hold_next = '0;
      end
    end
  end

  // Requests are formed two bits wider than the register so that neither
  // overshoot nor undershoot can wrap before being clamped.
  always_comb begin
    w_inc_next = w_req[ACC_W-1:0];
    if (w_req > C_CEIL_EXT) begin
      w_inc_next = C_CEIL;
    end else if (w_req < C_FLOOR_EXT) begin
      w_inc_next = C_FLOOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_rise   <= 1'b0;
      r_inc    <= C_BASE;
      r_hold   <= '0;
      r_locked <= 1'b0;
      r_at_max <= 1'b0;
      r_at_min <= 1'b0;
    end else begin
      r_acc    <= w_sum[ACC_W-1:0];
      r_rise   <= w_sum[ACC_W];
      r_inc    <= w_inc_next;
      r_hold   <= w_hold_next;
      r_locked <= (w_hold_next == C_LOCK);
      r_at_max <= (w_inc_next == C_CEIL);
      r_at_min <= (w_inc_next == C_FLOOR);
    end
  end

  assign bus.clock_out  = r_acc[ACC_W-1];
  assign bus.clock_rise = r_rise;
  assign bus.cur_inc    = r_inc;
  assign bus.at_max     = r_at_max;
  assign bus.at_min     = r_at_min;
  assign bus.locked     = r_locked;

endmodule

`default_nettype wire
